alu_req_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares a single `tinyalu` datapath between two independent requesters. It accepts operand/opcode requests over valid/ready, drives the ALU `start`/`op`/`A`/`B` inputs with the start-until-done protocol, and returns the 16-bit result to the winning requester. It filters no-op and illegal opcodes and enforces a done-timeout. It sits directly in front of the ALU start/done interface; the bus/memory side is untouched.

---
 rtl/alu_req_arbiter.sv | 158 +++++++++++++++
 tb/tb_alu_req_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for the shared tinyalu datapath.
// Accepts one request at a time, runs it through the ALU start/done handshake and strobes the result back.
module alu_req_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_A0,
  input  logic [7:0]  req_B0,
  input  logic [7:0]  req_A1,
  input  logic [7:0]  req_B1,
  input  logic [2:0]  req_op0,
  input  logic [2:0]  req_op1,
  output logic [1:0]  rsp_valid,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant;
  logic        r_owner;
  logic [7:0]  r_A;
  logic [7:0]  r_B;
  logic [2:0]  r_op;
  logic [7:0]  r_timer;
  logic [15:0] r_result;
  logic        r_err;

  logic        w_any;
  logic        w_gnt;
  logic        w_accept;
  logic [7:0]  w_sel_A;
  logic [7:0]  w_sel_B;
  logic [2:0]  w_sel_op;
  logic        w_load_rsp;
  logic [15:0] w_rsp_result;
  logic        w_rsp_err;

  // With both requesters valid the one that did not win last time gets the grant.
  always_comb begin
    w_any    = |req_valid;
    w_gnt    = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
    w_accept = (r_state == ST_IDLE) && w_any;
    w_sel_A  = w_gnt ? req_A1  : req_A0;
    w_sel_B  = w_gnt ? req_B1  : req_B0;
    w_sel_op = w_gnt ? req_op1 : req_op0;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load_rsp   = 1'b0;
    w_rsp_result = '0;
    w_rsp_err    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          unique case (w_sel_op)
            3'd1, 3'd2, 3'd3, 3'd4: w_state_nxt = ST_BUSY;
            3'd0: begin
              w_state_nxt = ST_RESP;
              w_load_rsp  = 1'b1;
            end
            default: begin
              w_state_nxt = ST_RESP;
              w_load_rsp  = 1'b1;
              w_rsp_err   = 1'b1;
            end
          endcase
        end
      end
      ST_BUSY: begin
        // done takes priority over a timeout landing in the same cycle
        if (alu_done) begin
          w_state_nxt  = ST_RESP;
          w_load_rsp   = 1'b1;
          w_rsp_result = alu_result;
        end else if (r_timer == TMO_LAST) begin
          w_state_nxt = ST_RESP;
          w_load_rsp  = 1'b1;
          w_rsp_err   = 1'b1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_A          <= '0;
      r_B          <= '0;
      r_op         <= '0;
      r_timer      <= '0;
      r_result     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_A          <= w_sel_A;
        r_B          <= w_sel_B;
        r_op         <= w_sel_op;
        r_owner      <= w_gnt;
        r_last_grant <= w_gnt;
      end
      if (r_state == ST_BUSY) begin
        r_timer <= r_timer + 8'd1;
      end else begin
        r_timer <= '0;
      end
      // Response fields persist after the strobe until the next response loads them.
      if (w_load_rsp) begin
        r_result <= w_rsp_result;
        r_err    <= w_rsp_err;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset_n && w_accept) begin
      req_ready = w_gnt ? 2'b10 : 2'b01;
    end
    rsp_valid = '0;
    if (r_state == ST_RESP) begin
      rsp_valid = r_owner ? 2'b10 : 2'b01;
    end
  end

  assign rsp_result = r_result;
  assign rsp_err    = r_err;
  assign alu_A      = r_A;
  assign alu_B      = r_B;
  assign alu_op     = r_op;
  assign alu_start  = (r_state == ST_BUSY);
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural tinyalu stand-in and hand-computed expectations.
module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_A0, req_B0, req_A1, req_B1;
  logic [2:0]  req_op0, req_op1;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic [7:0]  alu_A, alu_B;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  // ALU stand-in: done pulses m_delay+1 cycles into start, never if m_never is set.
  int   m_delay = 0;
  bit   m_never = 1'b0;
  int   m_cnt   = 0;

  alu_req_arbiter #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_A0     (req_A0),
    .req_B0     (req_B0),
    .req_A1     (req_A1),
    .req_B1     (req_B1),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!alu_start) begin
      m_cnt    <= 0;
      alu_done <= 1'b0;
    end else begin
      m_cnt    <= m_cnt + 1;
      alu_done <= !m_never && (m_cnt == m_delay);
      case (alu_op)
        3'd1:    alu_result <= {8'h00, alu_A} + {8'h00, alu_B};
        3'd2:    alu_result <= {8'h00, alu_A & alu_B};
        3'd3:    alu_result <= {8'h00, alu_A ^ alu_B};
        3'd4:    alu_result <= {8'h00, alu_A} * {8'h00, alu_B};
        default: alu_result <= '0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the grant in the current IDLE cycle, then advances past the accept edge.
  task automatic accept(input string tag, input logic [1:0] exp_ready);
    #1;
    chk(tag, {30'd0, req_ready}, {30'd0, exp_ready});
    tick();
  endtask

  // lat counts cycles from the accept edge; 1 means the response is in the cycle right after accept.
  task automatic wait_rsp(input int limit, output int lat, output bit start_seen);
    lat = 1;
    start_seen = 1'b0;
    while (rsp_valid == 2'b00 && lat < limit) begin
      if (alu_start) start_seen = 1'b1;
      tick();
      lat++;
    end
    chk("rsp_arrived", {31'd0, rsp_valid != 2'b00}, 32'd1);
  endtask

  task automatic pulse_reset();
    req_valid = 2'b00;
    reset_n   = 1'b0;
    #3;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit sseen;
    logic [1:0]  exp_g [4]  = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] exp_r [4]  = '{16'h000F, 16'h00FF, 16'h000F, 16'h00FF};

    reset_n   = 1'b0;
    req_valid = 2'b11;
    req_A0 = 8'h00; req_B0 = 8'h00; req_op0 = 3'd0;
    req_A1 = 8'h00; req_B1 = 8'h00; req_op1 = 3'd0;
    #12;
    chk("rst_ready",  {30'd0, req_ready}, 32'd0);
    chk("rst_start",  {31'd0, alu_start}, 32'd0);
    chk("rst_busy",   {31'd0, busy},      32'd0);
    chk("rst_rspv",   {30'd0, rsp_valid}, 32'd0);
    chk("rst_result", {16'd0, rsp_result}, 32'd0);
    chk("rst_err",    {31'd0, rsp_err},   32'd0);
    chk("rst_aluops", {13'd0, alu_A, alu_B, alu_op}, 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // add 0x0F + 0x01 from requester 0
    m_delay = 0;
    req_valid = 2'b01; req_A0 = 8'h0F; req_B0 = 8'h01; req_op0 = 3'd1;
    accept("add_ready", 2'b01);
    req_valid = 2'b00;
    chk("add_start", {31'd0, alu_start}, 32'd1);
    chk("add_busy",  {31'd0, busy},      32'd1);
    chk("add_aluin", {13'd0, alu_A, alu_B, alu_op}, {13'd0, 8'h0F, 8'h01, 3'd1});
    wait_rsp(10, lat, sseen);
    chk("add_rspv",   {30'd0, rsp_valid}, 32'd1);
    chk("add_result", {16'd0, rsp_result}, 32'h0010);
    chk("add_err",    {31'd0, rsp_err},   32'd0);
    chk("add_sseen",  {31'd0, sseen},     32'd1);
    chk("add_lat",    lat, 32'd3);
    tick();
    chk("add_rsp_one", {30'd0, rsp_valid}, 32'd0);
    chk("add_hold",   {16'd0, rsp_result}, 32'h0010);

    // both requesters always valid: mul 3*5 on 0, xor AA^55 on 1
    pulse_reset();
    req_A0 = 8'h03; req_B0 = 8'h05; req_op0 = 3'd4;
    req_A1 = 8'hAA; req_B1 = 8'h55; req_op1 = 3'd3;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      accept($sformatf("rr_grant%0d", i), exp_g[i]);
      wait_rsp(10, lat, sseen);
      chk($sformatf("rr_rspv%0d", i),   {30'd0, rsp_valid}, {30'd0, exp_g[i]});
      chk($sformatf("rr_result%0d", i), {16'd0, rsp_result}, {16'd0, exp_r[i]});
      chk($sformatf("rr_err%0d", i),    {31'd0, rsp_err},   32'd0);
      chk($sformatf("rr_gap%0d", i),    {31'd0, alu_start}, 32'd0);
      if (i == 3) req_valid = 2'b00;
      tick();
    end

    // requester 0 add with no done from the ALU
    m_never = 1'b1;
    req_valid = 2'b01; req_A0 = 8'h11; req_B0 = 8'h22; req_op0 = 3'd1;
    accept("tmo_ready", 2'b01);
    req_valid = 2'b00;
    wait_rsp(40, lat, sseen);
    chk("tmo_lat",    lat, 32'd17);
    chk("tmo_rspv",   {30'd0, rsp_valid}, 32'd1);
    chk("tmo_result", {16'd0, rsp_result}, 32'd0);
    chk("tmo_err",    {31'd0, rsp_err},   32'd1);
    chk("tmo_start",  {31'd0, alu_start}, 32'd0);
    tick();
    m_never = 1'b0;

    // requester 1 no-op, then illegal op 6
    req_valid = 2'b10; req_A1 = 8'h12; req_B1 = 8'h34; req_op1 = 3'd0;
    accept("nop_ready", 2'b10);
    req_op1 = 3'd6;
    wait_rsp(10, lat, sseen);
    chk("nop_lat",    lat, 32'd1);
    chk("nop_rspv",   {30'd0, rsp_valid}, 32'd2);
    chk("nop_result", {16'd0, rsp_result}, 32'd0);
    chk("nop_err",    {31'd0, rsp_err},   32'd0);
    chk("nop_start",  {31'd0, alu_start | sseen}, 32'd0);
    tick();
    accept("ill_ready", 2'b10);
    req_valid = 2'b00;
    wait_rsp(10, lat, sseen);
    chk("ill_lat",    lat, 32'd1);
    chk("ill_rspv",   {30'd0, rsp_valid}, 32'd2);
    chk("ill_result", {16'd0, rsp_result}, 32'd0);
    chk("ill_err",    {31'd0, rsp_err},   32'd1);
    chk("ill_start",  {31'd0, alu_start | sseen}, 32'd0);
    tick();

    // reset during the second BUSY cycle of a mul
    m_delay = 5;
    req_valid = 2'b01; req_A0 = 8'h03; req_B0 = 8'h05; req_op0 = 3'd4;
    accept("mrst_ready", 2'b01);
    req_valid = 2'b00;
    tick();
    chk("mrst_pre_start", {31'd0, alu_start}, 32'd1);
    req_valid = 2'b11;
    reset_n = 1'b0;
    #1;
    chk("mrst_start_drop", {31'd0, alu_start}, 32'd0);
    chk("mrst_busy",       {31'd0, busy},      32'd0);
    chk("mrst_ready",      {30'd0, req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mrst_norsp%0d", i), {30'd0, rsp_valid}, 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    accept("mrst_first_grant", 2'b01);
    req_valid = 2'b00;
    wait_rsp(20, lat, sseen);
    chk("mrst_rspv",   {30'd0, rsp_valid}, 32'd1);
    chk("mrst_result", {16'd0, rsp_result}, 32'h000F);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
